// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and helpers for decoder_scan.
//   state_e     - FSM states IDLE / DIRECT / SCAN
//   onehot_msb  - MSB-first one-hot decode, sized for the widest supported select
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  // Widest select the helper supports; callers slice the low 2**sel_w bits.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT   = 1 << MAX_SEL_W;

  // Index k sets bit (2**sel_w - 1 - k), so index 0 lands on the MSB.
  function automatic logic [MAX_OUT-1:0] onehot_msb(input logic [MAX_SEL_W-1:0] sel,
                                                    input int unsigned           sel_w);
    logic [MAX_OUT-1:0] oh;
    oh = '0;
    oh[(1 << sel_w) - 1 - int'(sel)] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/decoder_dwell_cnt.sv
// decoder_dwell_cnt: loadable down-counter that parks at zero.
//   clk, rst    - clock, async active-high reset
//   load_i      - load load_val_i (wins over dec_i)
//   dec_i       - decrement by one; ignored once the count is zero
//   load_val_i  - value to load
//   zero_o      - count is zero
module decoder_dwell_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt_q <= '0;
    else if (load_i)                  cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N decoder with direct and scan modes.
//   clk, rst   - clock, async active-high reset
//   en         - enable; low forces y inactive and returns to IDLE
//   mode       - 0 direct decode of sel, 1 scan
//   sel        - direct select / scan start index
//   start      - pulse that launches or restarts a scan (mode=1)
//   dwell      - cycles per index minus one, sampled at load/reload
//   y          - registered MSB-first one-hot select (inverted if ACTIVE_LOW)
//   idx        - index currently driven on y
//   busy       - scanning
//   wrap       - one-cycle pulse when the scan index rolls over to 0
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  start,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  wrap
);

  localparam int                 OUT_W   = 1 << SEL_W;
  localparam logic [SEL_W-1:0]   IDX_MAX = '1;
  localparam logic [OUT_W-1:0]   Y_OFF   = {OUT_W{ACTIVE_LOW}};

  // Polarity is folded in before the register so y comes straight off flops.
  function automatic logic [OUT_W-1:0] dec_pol(input logic [SEL_W-1:0] s);
    logic [MAX_OUT-1:0] oh;
    oh = onehot_msb(MAX_SEL_W'(s), SEL_W);
    return oh[OUT_W-1:0] ^ Y_OFF;
  endfunction

  state_e             state_q;
  logic [OUT_W-1:0]   y_q;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               busy_q, wrap_q;
  logic               cnt_load, cnt_dec, cnt_zero;

  assign idx_d = idx_q + 1'b1;

  // Load on scan launch/restart and on every index advance (reload picks up
  // the current dwell input); otherwise count down while scanning.
  always_comb begin
    cnt_load = en && mode && (start || (state_q == SCAN && cnt_zero));
    cnt_dec  = en && mode && !start && state_q == SCAN && !cnt_zero;
  end

  decoder_dwell_cnt #(.W(DWELL_W)) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (dwell),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= Y_OFF;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
        y_q     <= Y_OFF;
        busy_q  <= 1'b0;
      end else if (mode && start) begin
        state_q <= SCAN;
        idx_q   <= sel;
        y_q     <= dec_pol(sel);
        busy_q  <= 1'b1;
      end else if (state_q == SCAN && mode) begin
        if (cnt_zero) begin
          idx_q  <= idx_d;
          y_q    <= dec_pol(idx_d);
          wrap_q <= (idx_q == IDX_MAX);
        end
      end else if (!mode || state_q == DIRECT) begin
        // DIRECT keeps decoding sel even with mode=1 until a start arrives.
        state_q <= DIRECT;
        idx_q   <= sel;
        y_q     <= dec_pol(sel);
        busy_q  <= 1'b0;
      end
      // IDLE with mode=1 and no start: hold inactive.
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, mode, start;
  logic [2:0] sel;
  logic [7:0] dwell;
  logic [7:0] y, y_lo;
  logic [2:0] idx, idx_lo;
  logic       busy, wrap, busy_lo, wrap_lo;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .start(start),
    .dwell(dwell), .y(y), .idx(idx), .busy(busy), .wrap(wrap)
  );

  decoder_scan #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .start(start),
    .dwell(dwell), .y(y_lo), .idx(idx_lo), .busy(busy_lo), .wrap(wrap_lo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // direct sweep, one-hot MSB-first
  logic [7:0] y_dir [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  // scan sel=6 dwell=2
  logic [2:0] sc_idx  [10] = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd1};
  logic       sc_wrap [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  // active-low scan sel=0 dwell=0
  logic [7:0] lo_y    [9] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'h7F};
  logic       lo_wrap [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; sel = 3'd0; dwell = 8'd0;
    #3;
    chk("rst_y",    32'(y),    32'h00);
    chk("rst_y_lo", 32'(y_lo), 32'hFF);
    chk("rst_idx",  32'(idx),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_y", 32'(y), 32'h00);

    // direct sweep
    en = 1'b1; mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      chk($sformatf("dir_y%0d", s),   32'(y),   32'(y_dir[s]));
      chk($sformatf("dir_idx%0d", s), 32'(idx), 32'(s));
    end

    // enable gating
    sel = 3'd5; en = 1'b0;
    tick();
    chk("en0_y",  32'(y),    32'h00);
    chk("en0_ylo",32'(y_lo), 32'hFF);
    en = 1'b1;
    tick();
    chk("en1_y",   32'(y),   32'h04);
    chk("en1_idx", 32'(idx), 32'd5);

    // scan sel=6 dwell=2
    mode = 1'b1; sel = 3'd6; dwell = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("scan_idx%0d", i),  32'(idx),  32'(sc_idx[i]));
      chk($sformatf("scan_wrap%0d", i), 32'(wrap), 32'(sc_wrap[i]));
      chk($sformatf("scan_busy%0d", i), 32'(busy), 32'd1);
      if (i == 0) chk("scan_y6", 32'(y), 32'h02);
      if (i == 3) chk("scan_y7", 32'(y), 32'h01);
      if (i == 6) chk("scan_y0", 32'(y), 32'h80);
      tick();
    end

    // restart mid-scan
    sel = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_idx",  32'(idx),  32'd3);
    chk("restart_y",    32'(y),    32'h10);
    chk("restart_wrap", 32'(wrap), 32'd0);

    // mode=0 drops back to direct
    mode = 1'b0;
    tick();
    chk("todir_busy", 32'(busy), 32'd0);
    chk("todir_y",    32'(y),    32'h10);

    // start with en=0 is ignored
    en = 1'b0; mode = 1'b1; sel = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("en0start_y",    32'(y),    32'h00);
    chk("en0start_busy", 32'(busy), 32'd0);
    en = 1'b1;
    tick();
    chk("idle_nostart_y",    32'(y),    32'h00);
    chk("idle_nostart_busy", 32'(busy), 32'd0);

    // active-low scan from 0, dwell=0
    sel = 3'd0; dwell = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("lo_y%0d", i),    32'(y_lo),    32'(lo_y[i]));
      chk($sformatf("lo_wrap%0d", i), 32'(wrap_lo), 32'(lo_wrap[i]));
      chk($sformatf("lo_idx%0d", i),  32'(idx_lo),  32'(i % 8));
      tick();
    end

    // async reset mid-scan
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ylo",  32'(y_lo),    32'hFF);
    chk("arst_y",    32'(y),       32'h00);
    chk("arst_idx",  32'(idx_lo),  32'd0);
    chk("arst_busy", 32'(busy_lo), 32'd0);
    chk("arst_wrap", 32'(wrap_lo), 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("norestart_busy", 32'(busy_lo), 32'd0);
    chk("norestart_ylo",  32'(y_lo),    32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered N-to-2^N decoder with enable, the successor to the team's combinational 3-to-8 decoder. Adds a registered direct mode, an autonomous scan mode that walks the active output across all 2^N lines with a programmable dwell, and selectable output polarity. Intended for row/digit-select and chip-select fan-out where glitch-free, clocked select lines are required.

## Interface
- SEL_W, 3, select width; output width is 2**SEL_W
- DWELL_W, 8, width of the dwell-count input
- ACTIVE_LOW, 0, 1 inverts every bit of y (inactive = 1)

- clk  in  1  single clock, rising edge
- rst  in  1  reset: asynchronous, active-high
- en  in  1  decoder enable; low forces y inactive
- mode  in  1  0 = direct decode of sel, 1 = scan
- sel  in  SEL_W  direct-mode select; scan-mode start index
- start  in  1  one-cycle pulse, launches or restarts a scan (mode=1 only)
- dwell  in  DWELL_W  cycles each index is held, minus 1 (0 = advance every cycle)
- y  out  2**SEL_W  registered one-hot select lines
- idx  out  SEL_W  index currently driven on y
- busy  out  1  high while scanning
- wrap  out  1  one-cycle pulse when scan index moves from 2**SEL_W-1 to 0

## Operation
- Bit order is MSB-first: index k asserts y[2**SEL_W-1-k] (index 0 -> y=1000_0000 for SEL_W=3).
- FSM states: IDLE, DIRECT, SCAN.
- IDLE: y inactive, busy=0. en=1 & mode=0 -> DIRECT; en=1 & mode=1 & start -> SCAN.
- DIRECT: each cycle y <= decode(sel), idx <= sel. mode=1 & start -> SCAN; en=0 -> IDLE.
- SCAN: on entry idx <= sel, dwell counter <= dwell, busy=1. Counter decrements each cycle; at 0 idx <= idx+1 (mod 2**SEL_W) and counter reloads from current dwell input. Scan runs indefinitely until en=0 (-> IDLE) or mode=0 (-> DIRECT).
- start while in SCAN restarts from current sel with a fresh dwell count.
- en=0 has priority over start and mode.
- dwell is sampled only at load/reload; changes mid-dwell take effect at the next reload.
- Dwell counter is DWELL_W bits, decrement-only, never wraps below 0.
- Outputs after reset: y all-inactive (0, or all 1s if ACTIVE_LOW), idx=0, busy=0, wrap=0, state IDLE.

## Timing
- All outputs registered; latency sel/en/mode -> y is 1 cycle.
- start sampled at edge T: y shows decode(sel) from T+1, busy=1 from T+1.
- Each index held exactly dwell+1 cycles; full rotation = 2**SEL_W*(dwell+1) cycles.
- wrap high for exactly the cycle in which idx first reads 0 after 2**SEL_W-1; not asserted on the initial load, even when sel=0.
- en falling at edge T: y inactive and busy=0 from T+1.
- rst asserted mid-scan: outputs reach reset values immediately (asynchronous), no wrap pulse; scan does not resume after release until a new start.
- Exactly one bit of y active whenever en=1 and state is DIRECT or SCAN; never more than one during transitions.

## Structure
- Package decoder_pkg: state enum (IDLE, DIRECT, SCAN) and function onehot_msb(sel) returning the MSB-first one-hot vector.
- One sub-module, decoder_dwell_cnt: loadable DWELL_W down-counter with load, dec and zero outputs. FSM, index register and output register stay in decoder_scan.

## Test plan
- Reset, SEL_W=3: during and after rst, y=0000_0000, idx=0, busy=0, wrap=0.
- Direct sweep: en=1, mode=0, sel=0..7 one per cycle -> y = 1000_0000 ... 0000_0001, each one cycle after sel.
- en=0 with sel=5 -> y=0000_0000 next cycle; en=1 -> y=0000_0100 next cycle.
- Scan: sel=6, dwell=2, start -> idx 6,6,6,7,7,7,0,... ; wrap high only on first idx=0 cycle; busy=1 throughout.
- Restart/override: start with sel=3 mid-scan -> idx=3 next cycle; start with en=0 -> stays IDLE, y inactive.
- ACTIVE_LOW=1, dwell=0 scan from 0 -> y = 0111_1111, 1011_1111, ... advancing every cycle; rst mid-scan -> y=1111_1111 immediately.
